// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation UART receiver.
// Frame entries carry error flags alongside right-aligned data.
package uart_sim_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ENTRY_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/uart_sim_fifo.sv
// First-word-fall-through frame buffer.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_sim_fifo
    import uart_sim_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign level_o = level_q;

    // Pointer, storage and occupancy update.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/uart_sim_rx_fifo.sv
// Simulation UART receiver with parity/framing checks and FWFT buffer.
// Samples every line bit from the last synchronizer stage.
module uart_sim_rx_fifo
    import uart_sim_pkg::*;
#(
    parameter int BAUD_RATE  = 19200,
    parameter int CLOCK_FREQ = 100000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PRINT_EN   = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        txd_i,
    output logic [7:0]                  data_o,
    output logic                        perr_o,
    output logic                        ferr_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        overrun_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int CW       = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] HALF      = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] RELOAD    = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    state_e        state_q, state_d;
    logic [4:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          overrun_q, overrun_d;

    logic          rx;
    logic          start_det;
    logic          tick;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          ferr_now;
    entry_t        wentry;
    entry_t        rentry;

    assign rx        = sync_q[4];
    assign start_det = (sync_q[4:1] == 4'b1100);
    assign tick      = (cnt_q == '0);
    assign pop       = !empty && ready_i;
    assign ferr_now  = ferr_q | !rx;

    assign wentry.ferr = ferr_now;
    assign wentry.perr = perr_q;
    assign wentry.data = shreg_q;

    // Frame FSM, baud/bit counters, parity and stop checks.
    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[3:0], txd_i};
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    cnt_d   = HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = RELOAD;
                    bit_d   = '0;
                    shreg_d = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d[bit_q[2:0]] = rx;
                    par_d = par_q ^ rx;
                    cnt_d = RELOAD;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (PARITY == PAR_ODD) begin
                        perr_d = !(par_q ^ rx);
                    end else begin
                        perr_d = par_q ^ rx;
                    end
                    cnt_d   = RELOAD;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d  = RELOAD;
                    ferr_d = ferr_now;
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Overrun is sticky until reset.
    always_comb begin
        overrun_d = overrun_q | (push && full && !pop);
    end

    // Receiver state registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    // Echo completed frames, including dropped and errored ones.
    always_ff @(posedge clk_i) begin
        if (PRINT_EN != 0 && rstn_i && push) begin
            if (shreg_q >= 8'd32 && shreg_q <= 8'd127) begin
                $write("%c", shreg_q);
            end else if (shreg_q == 8'd10) begin
                $display("");
            end
        end
    end

    uart_sim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rentry),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign data_o    = rentry.data;
    assign perr_o    = rentry.perr;
    assign ferr_o    = rentry.ferr;
    assign valid_o   = !empty;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_sim_rx_fifo.sv
// Directed bench: 8N1, 8E1 and 7N2 receivers on a shared clock.
// Line bits last 16 cycles each (BAUD_DIV=16).
module tb_uart_sim_rx_fifo;

    logic       clk;
    logic       rstn;
    logic       txd   [3];
    logic       ready [3];
    logic [7:0] dat   [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       valid [3];
    logic       ovr   [3];
    logic [2:0] lvl   [3];

    int checks = 0;
    int errors = 0;

    int         pops   [3];
    logic [7:0] last_d [3];
    logic       last_p [3];
    logic       last_f [3];
    int         vcnt0;
    logic [7:0] q0 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_sim_rx_fifo #(
        .BAUD_RATE(20000), .CLOCK_FREQ(320000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .PRINT_EN(1)
    ) u_8n1 (
        .clk_i(clk), .rstn_i(rstn), .txd_i(txd[0]),
        .data_o(dat[0]), .perr_o(perr[0]), .ferr_o(ferr[0]),
        .valid_o(valid[0]), .ready_i(ready[0]),
        .overrun_o(ovr[0]), .level_o(lvl[0])
    );

    uart_sim_rx_fifo #(
        .BAUD_RATE(20000), .CLOCK_FREQ(320000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .PRINT_EN(0)
    ) u_8e1 (
        .clk_i(clk), .rstn_i(rstn), .txd_i(txd[1]),
        .data_o(dat[1]), .perr_o(perr[1]), .ferr_o(ferr[1]),
        .valid_o(valid[1]), .ready_i(ready[1]),
        .overrun_o(ovr[1]), .level_o(lvl[1])
    );

    uart_sim_rx_fifo #(
        .BAUD_RATE(20000), .CLOCK_FREQ(320000), .DATA_BITS(7),
        .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4), .PRINT_EN(0)
    ) u_7n2 (
        .clk_i(clk), .rstn_i(rstn), .txd_i(txd[2]),
        .data_o(dat[2]), .perr_o(perr[2]), .ferr_o(ferr[2]),
        .valid_o(valid[2]), .ready_i(ready[2]),
        .overrun_o(ovr[2]), .level_o(lvl[2])
    );

    // Consumer-side monitor: records every accepted head entry.
    initial begin
        for (int i = 0; i < 3; i++) begin
            pops[i] = 0;
            last_d[i] = '0;
            last_p[i] = 1'b0;
            last_f[i] = 1'b0;
        end
        vcnt0 = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rstn && valid[i] && ready[i]) begin
                pops[i]   = pops[i] + 1;
                last_d[i] = dat[i];
                last_p[i] = perr[i];
                last_f[i] = ferr[i];
                if (i == 0) q0.push_back(dat[0]);
            end
        end
        if (valid[0]) vcnt0 = vcnt0 + 1;
    end

    task automatic drive_bit(input int i, input logic b);
        txd[i] = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input int i, input logic [7:0] d,
                              input int nd, input int hp,
                              input logic pb, input int ns,
                              input logic s2);
        drive_bit(i, 1'b0);
        for (int k = 0; k < nd; k++) drive_bit(i, d[k]);
        if (hp != 0) drive_bit(i, pb);
        drive_bit(i, 1'b1);
        if (ns == 2) drive_bit(i, s2);
        txd[i] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_zero(input int i, input string nm);
        checks++;
        if (dat[i] !== 8'h00 || perr[i] !== 1'b0 || ferr[i] !== 1'b0 ||
            valid[i] !== 1'b0 || ovr[i] !== 1'b0 || lvl[i] !== 3'd0) begin
            errors++;
            $display("FAIL %s inst%0d: data=%h perr=%b ferr=%b valid=%b ovr=%b lvl=%0d, want all 0",
                     nm, i, dat[i], perr[i], ferr[i], valid[i], ovr[i], lvl[i]);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            txd[i] = 1'b1;
            ready[i] = 1'b1;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset_held");
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset_idle");
    endtask

    task automatic test_8n1();
        int p0;
        int v0;
        p0 = pops[0];
        v0 = vcnt0;
        send_frame(0, 8'h41, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (pops[0] !== p0 + 1) begin
            errors++;
            $display("FAIL 8n1_pops got %0d want %0d", pops[0] - p0, 1);
        end
        checks++;
        if (last_d[0] !== 8'h41 || last_p[0] !== 1'b0 || last_f[0] !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_frame got d=%h p=%b f=%b want d=41 p=0 f=0",
                     last_d[0], last_p[0], last_f[0]);
        end
        checks++;
        if (vcnt0 - v0 !== 1) begin
            errors++;
            $display("FAIL 8n1_valid_cycles got %0d want 1", vcnt0 - v0);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8'h55, 8, 1, 1'b0, 1, 1'b1);
        checks++;
        if (pops[1] !== 1 || last_d[1] !== 8'h55 || last_p[1] !== 1'b0 || last_f[1] !== 1'b0) begin
            errors++;
            $display("FAIL par_good got pops=%0d d=%h p=%b f=%b want 1 55 0 0",
                     pops[1], last_d[1], last_p[1], last_f[1]);
        end
        send_frame(1, 8'h55, 8, 1, 1'b1, 1, 1'b1);
        checks++;
        if (pops[1] !== 2 || last_d[1] !== 8'h55 || last_p[1] !== 1'b1 || last_f[1] !== 1'b0) begin
            errors++;
            $display("FAIL par_bad got pops=%0d d=%h p=%b f=%b want 2 55 1 0",
                     pops[1], last_d[1], last_p[1], last_f[1]);
        end
    endtask

    task automatic test_framing();
        send_frame(2, 8'h3F, 7, 0, 1'b0, 2, 1'b0);
        checks++;
        if (pops[2] !== 1 || last_d[2] !== 8'h3F || last_f[2] !== 1'b1 || last_p[2] !== 1'b0) begin
            errors++;
            $display("FAIL ferr got pops=%0d d=%h f=%b p=%b want 1 3f 1 0",
                     pops[2], last_d[2], last_f[2], last_p[2]);
        end
        send_frame(2, 8'h2A, 7, 0, 1'b0, 2, 1'b1);
        checks++;
        if (pops[2] !== 2 || last_d[2] !== 8'h2A || last_f[2] !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clean got pops=%0d d=%h f=%b want 2 2a 0",
                     pops[2], last_d[2], last_f[2]);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp = 8'h10 + 8'(k);
            send_frame(0, exp, 8, 0, 1'b0, 1, 1'b1);
        end
        checks++;
        if (lvl[0] !== 3'd4 || ovr[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_full got lvl=%0d ovr=%b want 4 1", lvl[0], ovr[0]);
        end
        checks++;
        if (valid[0] !== 1'b1 || dat[0] !== 8'h10) begin
            errors++;
            $display("FAIL ovr_head got valid=%b d=%h want 1 10", valid[0], dat[0]);
        end
        q0.delete();
        ready[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (q0.size() !== 4) begin
            errors++;
            $display("FAIL ovr_drain_count got %0d want 4", q0.size());
        end
        for (int k = 0; k < 4; k++) begin
            exp = 8'h10 + 8'(k);
            if (k < q0.size()) begin
                checks++;
                if (q0[k] !== exp) begin
                    errors++;
                    $display("FAIL ovr_order[%0d] got %h want %h", k, q0[k], exp);
                end
            end
        end
        checks++;
        if (lvl[0] !== 3'd0 || valid[0] !== 1'b0 || ovr[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_after got lvl=%0d valid=%b ovr=%b want 0 0 1",
                     lvl[0], valid[0], ovr[0]);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pops[0];
        txd[0] = 1'b0;
        repeat (3) @(negedge clk);
        txd[0] = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (pops[0] !== p0 || valid[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            errors++;
            $display("FAIL glitch got pops=%0d valid=%b lvl=%0d want 0 0 0",
                     pops[0] - p0, valid[0], lvl[0]);
        end
        send_frame(0, 8'h5A, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (pops[0] !== p0 + 1 || last_d[0] !== 8'h5A || last_f[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_next got pops=%0d d=%h f=%b want 1 5a 0",
                     pops[0] - p0, last_d[0], last_f[0]);
        end
    endtask

    task automatic test_midreset();
        int p0;
        logic [7:0] d;
        d = 8'hA5;
        p0 = pops[0];
        drive_bit(0, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(0, d[k]);
        rstn = 1'b0;
        txd[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_zero(0, "midreset_held");
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_zero(0, "midreset_idle");
        checks++;
        if (pops[0] !== p0) begin
            errors++;
            $display("FAIL midreset_push got %0d want 0", pops[0] - p0);
        end
        send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (pops[0] !== p0 + 1 || last_d[0] !== 8'hA5 || last_f[0] !== 1'b0 ||
            last_p[0] !== 1'b0 || ovr[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next got pops=%0d d=%h f=%b p=%b ovr=%b want 1 a5 0 0 0",
                     pops[0] - p0, last_d[0], last_f[0], last_p[0], ovr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_overrun();
        test_glitch();
        test_midreset();
        $display("");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
